// File: rtl/unity_ecc_pkg.sv
// GF(2^8) helpers and parity-column constants for the unity encoder.
// Shared by the encoder datapath and the optional UNITY_ENCODER_SELFCHECK_EN checker.
package unity_ecc_pkg;

  typedef logic [7:0] symbol_t;

  localparam int unsigned NumData = 8;

  // x^8+x^6+x^4+x^3+x^2+x+1; alpha = 0x02
  localparam logic [8:0] PrimPoly = 9'h15F;

  // Exponents of alpha applied to d0..d7; the second row is twice the first, mod 255
  localparam int unsigned C0Exp [NumData] = '{25, 39, 63, 108, 141, 184, 215, 230};
  localparam int unsigned C1Exp [NumData] = '{50, 78, 126, 216, 27, 113, 175, 205};

  typedef symbol_t [255:0] alpha_tbl_t;

  function automatic symbol_t gf_xtime(symbol_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? PrimPoly[7:0] : 8'h00);
  endfunction

  // Entry e holds alpha^e; entry 255 wraps back to 1
  function automatic alpha_tbl_t alpha_table();
    alpha_tbl_t t;
    symbol_t    p;
    p = 8'h01;
    for (int i = 0; i < 256; i++) begin
      t[i] = p;
      p    = gf_xtime(p);
    end
    return t;
  endfunction

  localparam alpha_tbl_t AlphaTbl = alpha_table();

  function automatic symbol_t gf_mul(symbol_t a, symbol_t b);
    symbol_t p;
    symbol_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiply by a compile-time power of alpha; folds to a fixed XOR matrix
  function automatic symbol_t gf_mul_const(symbol_t d, int unsigned e);
    logic [7:0] idx;
    idx = 8'(e % 255);
    return gf_mul(d, AlphaTbl[idx]);
  endfunction

endpackage

// File: rtl/unity_parity_gen.sv
// Constant-multiplier products of eight data symbols and the XOR reduction of a product set.
// The reduction input is separate so a registered product set can be reduced a stage later.
module unity_parity_gen
  import unity_ecc_pkg::*;
(
  input  logic [63:0] data_i,
  output logic [63:0] prod0_o,
  output logic [63:0] prod1_o,
  input  logic [63:0] prod0_i,
  input  logic [63:0] prod1_i,
  input  symbol_t     extra0_i,
  input  symbol_t     extra1_i,
  output symbol_t     parity0_o,
  output symbol_t     parity1_o
);

  // Product for d_i occupies the same byte lane as d_i
  for (genvar i = 0; i < NumData; i++) begin : g_prod
    assign prod0_o[63-8*i -: 8] = gf_mul_const(data_i[63-8*i -: 8], C0Exp[i]);
    assign prod1_o[63-8*i -: 8] = gf_mul_const(data_i[63-8*i -: 8], C1Exp[i]);
  end

  // extra*_i lets the same network add the stored parities to form a syndrome
  always_comb begin
    parity0_o = extra0_i;
    parity1_o = extra1_i;
    for (int i = 0; i < NumData; i++) begin
      parity0_o ^= prod0_i[8*i +: 8];
      parity1_o ^= prod1_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/unity_encoder.sv
// Two-stage systematic GF(2^8) encoder: 8 data symbols in, 80-bit codeword with P0/P1 out.
// Define UNITY_ENCODER_SELFCHECK_EN to add the sticky syndrome checker and selfcheck_err port.
module unity_encoder
  import unity_ecc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] codeword_out,
`ifdef UNITY_ENCODER_SELFCHECK_EN
  output logic        selfcheck_err,
`endif
  output logic [15:0] cw_count
);

  logic        s1_valid_q, s1_valid_d;
  logic [63:0] s1_data_q, s1_data_d;
  logic [63:0] s1_prod0_q, s1_prod0_d;
  logic [63:0] s1_prod1_q, s1_prod1_d;
  logic        out_valid_q, out_valid_d;
  logic [79:0] codeword_q, codeword_d;
  logic [15:0] cw_count_q, cw_count_d;

  logic        s2_adv;
  logic        in_hs;
  logic        out_hs;
  logic [63:0] prod0, prod1;
  symbol_t     par0, par1;

  unity_parity_gen u_enc (
    .data_i    (in_data),
    .prod0_o   (prod0),
    .prod1_o   (prod1),
    .prod0_i   (s1_prod0_q),
    .prod1_i   (s1_prod1_q),
    .extra0_i  (8'h00),
    .extra1_i  (8'h00),
    .parity0_o (par0),
    .parity1_o (par1)
  );

  // S1 may also fill while S2 is stalled, as long as S1 itself is empty
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_prod0_d  = s1_prod0_q;
    s1_prod1_d  = s1_prod1_q;
    out_valid_d = out_valid_q;
    codeword_d  = codeword_q;
    cw_count_d  = cw_count_q;

    if (in_ready) s1_valid_d = in_valid;
    if (in_hs) begin
      s1_data_d  = in_data;
      s1_prod0_d = prod0;
      s1_prod1_d = prod1;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) codeword_d = {s1_data_q, par0, par1};
    end

    if (out_hs) cw_count_d = cw_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_prod0_q  <= '0;
      s1_prod1_q  <= '0;
      out_valid_q <= 1'b0;
      codeword_q  <= '0;
      cw_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_prod0_q  <= s1_prod0_d;
      s1_prod1_q  <= s1_prod1_d;
      out_valid_q <= out_valid_d;
      codeword_q  <= codeword_d;
      cw_count_q  <= cw_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign codeword_out = codeword_q;
  assign cw_count     = cw_count_q;

`ifdef UNITY_ENCODER_SELFCHECK_EN
  logic [63:0] chk_prod0, chk_prod1;
  symbol_t     syn0, syn1;
  logic        err_q, err_d;

  // Re-encoding the stored data and folding in the stored parities yields the syndrome
  unity_parity_gen u_check (
    .data_i    (codeword_q[79:16]),
    .prod0_o   (chk_prod0),
    .prod1_o   (chk_prod1),
    .prod0_i   (chk_prod0),
    .prod1_i   (chk_prod1),
    .extra0_i  (codeword_q[15:8]),
    .extra1_i  (codeword_q[7:0]),
    .parity0_o (syn0),
    .parity1_o (syn1)
  );

  assign err_d = err_q || (out_valid_q && ((syn0 | syn1) != 8'h00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign selfcheck_err = err_q;
`endif

endmodule

// File: doc/unity_encoder.md
UNITY_ENCODER -- requirements
Module: unity_encoder

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-002 The port rst_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-003 The port in_valid SHALL be an input, 1 bit wide, and indicates that in_data is valid.
REQ-004 The port in_ready SHALL be an output, 1 bit wide, and indicates that the encoder can accept in_data.
REQ-005 The port in_data SHALL be an input, 64 bits wide; symbol d0 is [63:56] and symbol d7 is [7:0].
REQ-006 The port out_valid SHALL be an output, 1 bit wide, and indicates that codeword_out is valid.
REQ-007 The port out_ready SHALL be an input, 1 bit wide, and is the downstream accept.
REQ-008 The port codeword_out SHALL be an output, 80 bits wide: d0..d7 in [79:16], P0 in [15:8], P1 in [7:0].
REQ-009 The port cw_count SHALL be an output, 16 bits wide, and counts codewords accepted at the output.
REQ-010 The port selfcheck_err SHALL be an output, 1 bit wide, and exists only under UNITY_ENCODER_SELFCHECK_EN.

Function
REQ-011 Arithmetic SHALL be in GF(2^8) with primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1 (0x15F), where alpha = 0x02.
REQ-012 P0 SHALL equal the XOR over i of a^c0[i]*d_i, with c0 = {25,39,63,108,141,184,215,230}.
REQ-013 P1 SHALL equal the XOR over i of a^c1[i]*d_i, with c1 = {50,78,126,216,27,113,175,205}, i.e. c1 = 2*c0 mod 255.
REQ-014 The datapath SHALL be a 2-stage pipeline:
- S1 registers the 16 constant-multiplier products together with the data.
- S2 registers the XOR reductions and drives codeword_out.
REQ-015 Latency SHALL be exactly 2 cycles from an input handshake to out_valid, provided no backpressure is applied.
REQ-016 A handshake SHALL occur when valid and ready are both high on the same rising edge.
REQ-017 Stage S2 SHALL load when it is empty or when out_ready=1; S1 SHALL advance under the same condition.
REQ-018 in_ready SHALL equal (!S1_valid || S2 advancing), which sustains 1 codeword per cycle.
REQ-019 While out_valid=1 and out_ready=0, codeword_out SHALL be held stable and out_valid SHALL not drop.
REQ-020 Simultaneous input accept and output accept in the same cycle SHALL be lossless and SHALL not create a bubble.
REQ-021 cw_count SHALL increment on each output handshake and SHALL wrap from 0xFFFF to 0x0000.
REQ-022 in_valid=0 SHALL propagate bubbles through the pipeline without changing cw_count.

Reset
REQ-023 Asserting rst_n low SHALL immediately force out_valid=0, S1_valid=0, cw_count=0, codeword_out=0 and selfcheck_err=0.
REQ-024 in_ready SHALL read 1 during reset and in the first cycle after reset.
REQ-025 A reset asserted mid-stream SHALL discard all in-flight codewords, with no partial output afterward.

Configuration
REQ-026 With UNITY_ENCODER_SELFCHECK_EN defined, the block SHALL recompute the syndromes S0/S1 of the S2 register using the H-matrix.
- H-matrix: the c0/c1 columns, followed by identity columns for P0 and P1.
REQ-027 In that case, selfcheck_err SHALL go high and stay sticky until reset if any valid output has a nonzero syndrome.
REQ-028 Without the macro, the checker logic and the selfcheck_err port SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-029 The package unity_ecc_pkg SHALL hold:
- the primitive polynomial constant;
- the c0/c1 exponent tables;
- a 256-entry alpha-power table function;
- a gf_mul_const function;
- a symbol typedef (logic [7:0]).
REQ-030 One sub-module, unity_parity_gen, SHALL hold the combinational product/XOR network.
- Its XOR network SHALL be reused for the self-check syndrome.

Verification
REQ-031 After reset, in_data=0 SHALL give codeword_out=80'h0 at cycle +2, with cw_count=1 after the output handshake.
REQ-032 in_data=64'h0100_0000_0000_0000 SHALL give P0=a^25 and P1=a^50; in_data=64'h0000_0000_0000_0001 SHALL give P0=a^230 and P1=a^205.
- Expected values come from the package table.
REQ-033 Linearity: the parities of A XOR B SHALL equal parity(A) XOR parity(B) across 1000 random pairs.
- Every output SHALL also decode with zero syndrome.
REQ-034 Backpressure: with 4 back-to-back inputs and out_ready=0 for 5 cycles, in_ready SHALL fall after 2 accepts.
- The outputs SHALL then appear in order, held stable, with no loss or duplication.
REQ-035 With rst_n pulsed low mid-burst, out_valid SHALL fall asynchronously and cw_count SHALL be 0.
- No stale codeword SHALL appear after release.
REQ-036 Wrap check: preset traffic to 65536 outputs; cw_count SHALL read 0.
- With SELFCHECK_EN defined, forcing one bit flip in the S2 register SHALL set selfcheck_err=1 and keep it set.
